dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  pipeline memory access
- req_we  in  1  1 = store
- index  in  8  set index
- offset  in  2  word offset
- hit0  in  1  way0 tag match and valid, from the tag compare
- hit1  in  1  way1 tag match and valid, from the tag compare
- valid0  in  1  way0 valid bit
- valid1  in  1  way1 valid bit
- dirty0  in  1  way0 dirty bit
- dirty1  in  1  way1 dirty bit
- l2_ack  in  1  L2 transfer complete; refill data valid this cycle
- block0_re  out  1  data/tag RAM read, way0
- block1_re  out  1  data/tag RAM read, way1
- block0_we  out  1  data RAM write, way0
- block1_we  out  1  data RAM write, way1
- tagcomp_hit  out  1  word-granular write select
- data_wd_l2_en  out  1  select the L2 line as write data
- data_wd_dc_en  out  1  merge the store word
- tag_we  out  1  tag/valid write to victim_way
- dirty_set  out  1  set dirty on hit_way
- dirty_clr  out  1  clear dirty on victim_way
- hit_way  out  1  way that hit
- victim_way  out  1  replacement way
- l2_req  out  1  L2 request
- l2_rw  out  1  1 = writeback, 0 = fill
- miss_stall  out  1  stall the pipeline
- req_done  out  1  access complete, 1-cycle pulse

Function
REQ-003 The state machine SHALL have the states IDLE, COMPARE, WRITE_BACK, ALLOCATE and REFETCH, with state in one register.
REQ-004 IDLE, on req_valid: assert block0_re and block1_re; latch index, offset and req_we; next state COMPARE.
REQ-005 COMPARE, hit (hit0|hit1):
- hit_way = hit1.
- Load: req_done=1; next state IDLE.
- Store: tagcomp_hit=1, data_wd_dc_en=1, block{hit_way}_we=1, dirty_set=1, req_done=1; next state IDLE.
- The write SHALL land in the word selected by the latched offset only.
REQ-006 COMPARE, miss:
- miss_stall=1.
- victim_way SHALL be frozen until the next IDLE.
- If the victim is valid and dirty, next state WRITE_BACK; otherwise ALLOCATE.
REQ-007 WRITE_BACK: l2_req=1, l2_rw=1; hold until l2_ack, then dirty_clr=1 and next state ALLOCATE.
REQ-008 ALLOCATE: l2_req=1, l2_rw=0. On l2_ack in the same cycle:
- block{victim_way}_we=1 with tagcomp_hit=0, so the full line is written.
- data_wd_l2_en=1 and tag_we=1.
- For a store, also data_wd_dc_en=1 (store word merged) and dirty_set=1 on victim_way.
- Next state REFETCH.
REQ-009 REFETCH: assert both read enables; next state COMPARE, which SHALL then hit.
- Load miss latency: 2 cycles plus the L2 wait cycles.
REQ-010 miss_stall SHALL be high from the COMPARE miss cycle through REFETCH, and low on the final COMPARE hit cycle.
REQ-011 req_valid outside IDLE SHALL be ignored; the pipeline holds it under stall.
REQ-012 If hit0 and hit1 are both high, way0 SHALL be selected.
REQ-013 l2_ack outside WRITE_BACK/ALLOCATE SHALL be ignored.
REQ-014 Every write enable SHALL be combinational from state; no enable SHALL be asserted for more than one cycle per event.

Reset
REQ-015 On rst, state SHALL go to IDLE and all outputs SHALL be 0 on the following cycle, including mid-miss.
REQ-016 An outstanding L2 transaction SHALL be abandoned on reset; l2_req SHALL drop the cycle after rst.

Configuration
REQ-017 DCACHE_LRU_EN defined:
- A 256x1 LRU array, cleared on reset, is indexed by index.
- On every hit or refill, LRU[index] = ~used_way.
- victim_way = LRU[index], except that an invalid way is preferred (way0 first).
REQ-018 DCACHE_LRU_EN undefined:
- victim_way comes from a 1-bit counter toggling every COMPARE miss, reset to 0.
- An invalid way is still preferred.

Verification
REQ-019 Load, index=0x05, hit1=1 -> COMPARE: hit_way=1, req_done=1, no write enables; 2 cycles total.
REQ-020 Store, offset=2, hit0=1 -> block0_we=1, tagcomp_hit=1, data_wd_dc_en=1, dirty_set=1 for exactly 1 cycle.
REQ-021 Load miss, both ways valid, victim clean, l2_ack after 3 cycles:
- Sequence ALLOCATE(3) -> REFETCH -> COMPARE hit.
- block{victim}_we and data_wd_l2_en high 1 cycle.
- miss_stall high 5 cycles.
REQ-022 Store miss, victim dirty -> WRITE_BACK (l2_rw=1) until ack, dirty_clr; ALLOCATE (l2_rw=0); fill cycle has data_wd_l2_en=1, data_wd_dc_en=1, dirty_set=1.
REQ-023 rst asserted in the second ALLOCATE wait cycle -> next cycle state IDLE, l2_req=0, miss_stall=0, no write.
REQ-024 LRU, with DCACHE_LRU_EN defined: hit way0 at index 7, then miss at index 7 with both valid -> victim_way=1.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: 2-way set-associative data cache controller.
//   Five-state FSM (IDLE/COMPARE/WRITE_BACK/ALLOCATE/REFETCH) that sequences
//   tag/data RAM reads, hit writes, dirty-victim writeback and line refill
//   from L2. Every enable is decoded combinationally from the current state.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_we/index/offset  pipeline access (latched in IDLE)
//   hit0/hit1, valid0/1, dirty0/1  tag compare result and per-way status bits
//   l2_ack                      L2 transfer done / refill data valid
//   block{0,1}_re/_we           RAM read / write enables per way
//   tagcomp_hit                 word-granular write select
//   data_wd_l2_en/data_wd_dc_en write-data muxing (L2 line / store word)
//   tag_we, dirty_set, dirty_clr   tag/valid and dirty bit updates
//   hit_way, victim_way         selected ways
//   l2_req, l2_rw               L2 request (1 = writeback, 0 = fill)
//   miss_stall, req_done        pipeline stall and completion pulse
// Build option: define DCACHE_LRU_EN for per-set LRU replacement; otherwise
//   a 1-bit round-robin counter picks the victim.
module dcache_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_we,
  input  logic [7:0] index,
  input  logic [1:0] offset,
  input  logic       hit0,
  input  logic       hit1,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       dirty0,
  input  logic       dirty1,
  input  logic       l2_ack,
  output logic       block0_re,
  output logic       block1_re,
  output logic       block0_we,
  output logic       block1_we,
  output logic       tagcomp_hit,
  output logic       data_wd_l2_en,
  output logic       data_wd_dc_en,
  output logic       tag_we,
  output logic       dirty_set,
  output logic       dirty_clr,
  output logic       hit_way,
  output logic       victim_way,
  output logic       l2_req,
  output logic       l2_rw,
  output logic       miss_stall,
  output logic       req_done
);

  typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE, REFETCH} state_t;

  typedef struct packed {
    logic [7:0] index;
    logic [1:0] offset;
    logic       we;
  } req_t;

  state_t     state, state_nxt;
  req_t       req_q;
  logic       in_miss;     // set from the COMPARE miss until the next IDLE
  logic       victim_q;    // victim frozen for the whole miss sequence
  logic       repl;        // replacement policy choice when both ways valid
  logic       victim_calc;
  logic       vic;
  logic       vic_dirty;
  logic       hit;
  logic       way_hit;
  logic [1:0] blk_re, blk_we;
  logic       hit_way_c;

  // Offset only steers the external data path; it is kept for that consumer.
  logic       unused_offset;
  assign unused_offset = ^req_q.offset;

  assign hit         = hit0 | hit1;
  assign way_hit     = hit1 & ~hit0;                 // way0 wins a double hit
  assign victim_calc = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : repl);
  assign vic         = in_miss ? victim_q : victim_calc;
  assign vic_dirty   = vic ? (valid1 & dirty1) : (valid0 & dirty0);

`ifdef DCACHE_LRU_EN
  logic [255:0] lru;
  always_ff @(posedge clk) begin
    if (rst)
      lru <= '0;
    else if (state == COMPARE && hit)
      lru[req_q.index] <= ~way_hit;
    else if (state == ALLOCATE && l2_ack)
      lru[req_q.index] <= ~victim_q;
  end
  assign repl = lru[req_q.index];
`else
  logic rr;
  logic unused_index;
  assign unused_index = ^req_q.index;
  always_ff @(posedge clk) begin
    if (rst)
      rr <= 1'b0;
    else if (state == COMPARE && !hit)
      rr <= ~rr;
  end
  assign repl = rr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= '0;
      in_miss  <= 1'b0;
      victim_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid)
        req_q <= '{index: index, offset: offset, we: req_we};
      if (state == COMPARE && !hit && !in_miss) begin
        victim_q <= victim_calc;
        in_miss  <= 1'b1;
      end
      if (state_nxt == IDLE)
        in_miss <= 1'b0;
    end
  end

  always_comb begin
    state_nxt     = state;
    blk_re        = 2'b00;
    blk_we        = 2'b00;
    tagcomp_hit   = 1'b0;
    data_wd_l2_en = 1'b0;
    data_wd_dc_en = 1'b0;
    tag_we        = 1'b0;
    dirty_set     = 1'b0;
    dirty_clr     = 1'b0;
    hit_way_c     = 1'b0;
    l2_req        = 1'b0;
    l2_rw         = 1'b0;
    miss_stall    = 1'b0;
    req_done      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          blk_re    = 2'b11;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          hit_way_c = way_hit;
          req_done  = 1'b1;
          // After a refill the store word was already merged on the fill
          // cycle, so the closing hit only completes the access.
          if (req_q.we && !in_miss) begin
            tagcomp_hit     = 1'b1;
            data_wd_dc_en   = 1'b1;
            blk_we[way_hit] = 1'b1;
            dirty_set       = 1'b1;
          end
          state_nxt = IDLE;
        end else begin
          miss_stall = 1'b1;
          state_nxt  = vic_dirty ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        miss_stall = 1'b1;
        l2_req     = 1'b1;
        l2_rw      = 1'b1;
        if (l2_ack) begin
          dirty_clr = 1'b1;
          state_nxt = ALLOCATE;
        end
      end
      ALLOCATE: begin
        miss_stall = 1'b1;
        l2_req     = 1'b1;
        if (l2_ack) begin
          blk_we[victim_q] = 1'b1;
          data_wd_l2_en    = 1'b1;
          tag_we           = 1'b1;
          if (req_q.we) begin
            data_wd_dc_en = 1'b1;
            dirty_set     = 1'b1;
          end
          state_nxt = REFETCH;
        end
      end
      REFETCH: begin
        miss_stall = 1'b1;
        blk_re     = 2'b11;
        state_nxt  = COMPARE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign block0_re  = blk_re[0];
  assign block1_re  = blk_re[1];
  assign block0_we  = blk_we[0];
  assign block1_we  = blk_we[1];
  assign hit_way    = hit_way_c;
  // Live choice only on the first miss compare; frozen value otherwise.
  assign victim_way = (state == COMPARE && !in_miss && !hit) ? victim_calc : victim_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req_valid, req_we, hit0, hit1, valid0, valid1, dirty0, dirty1, l2_ack;
  logic [7:0] index;
  logic [1:0] offset;
  logic block0_re, block1_re, block0_we, block1_we, tagcomp_hit, data_wd_l2_en;
  logic data_wd_dc_en, tag_we, dirty_set, dirty_clr, hit_way, victim_way;
  logic l2_req, l2_rw, miss_stall, req_done;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .index(index),
    .offset(offset), .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
    .dirty0(dirty0), .dirty1(dirty1), .l2_ack(l2_ack),
    .block0_re(block0_re), .block1_re(block1_re), .block0_we(block0_we),
    .block1_we(block1_we), .tagcomp_hit(tagcomp_hit), .data_wd_l2_en(data_wd_l2_en),
    .data_wd_dc_en(data_wd_dc_en), .tag_we(tag_we), .dirty_set(dirty_set),
    .dirty_clr(dirty_clr), .hit_way(hit_way), .victim_way(victim_way),
    .l2_req(l2_req), .l2_rw(l2_rw), .miss_stall(miss_stall), .req_done(req_done)
  );

  localparam logic [15:0] O_RE0 = 16'h8000, O_RE1 = 16'h4000, O_WE0 = 16'h2000,
    O_WE1 = 16'h1000, O_TCH = 16'h0800, O_L2EN = 16'h0400, O_DC = 16'h0200,
    O_TWE = 16'h0100, O_DSET = 16'h0080, O_DCLR = 16'h0040, O_HW = 16'h0020,
    O_VIC = 16'h0010, O_L2R = 16'h0008, O_RW = 16'h0004, O_MS = 16'h0002,
    O_DN = 16'h0001;
  localparam logic [15:0] O_RE = O_RE0 | O_RE1;
`ifdef DCACHE_LRU_EN
  localparam logic [15:0] LRU_VIC = O_VIC;
`else
  localparam logic [15:0] LRU_VIC = 16'h0000;
`endif

  typedef struct {
    logic [95:0] nm;
    logic        r, rv, we;
    logic [7:0]  idx;
    logic [1:0]  off;
    logic        h0, h1, v0, v1, d0, d1, ack;
    logic [15:0] exp;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad = 0;

  function automatic logic [15:0] outs();
    return {block0_re, block1_re, block0_we, block1_we, tagcomp_hit, data_wd_l2_en,
            data_wd_dc_en, tag_we, dirty_set, dirty_clr, hit_way, victim_way,
            l2_req, l2_rw, miss_stall, req_done};
  endfunction

  task automatic add(input logic [95:0] nm, input logic r, input logic rv, input logic we,
                     input logic [7:0] idx, input logic [1:0] off,
                     input logic h0, input logic h1, input logic v0, input logic v1,
                     input logic d0, input logic d1, input logic ack, input logic [15:0] e);
    vec_t v;
    v.nm = nm; v.r = r; v.rv = rv; v.we = we; v.idx = idx; v.off = off;
    v.h0 = h0; v.h1 = h1; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.ack = ack;
    v.exp = e;
    tv.push_back(v);
  endtask

  task automatic check(input logic [95:0] nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //   name        r  rv we idx    off h0 h1 v0 v1 d0 d1 ack exp
    add("rst0",      0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    // load hit way1
    add("ld_idle",   0, 1, 0, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0, O_RE);
    add("ld_cmp",    0, 0, 0, 8'h05, 0, 0, 1, 1, 1, 0, 0, 0, O_HW | O_DN);
    add("ld_back",   0, 0, 0, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    // store hit way0, offset 2
    add("st_idle",   0, 1, 1, 8'h09, 2, 0, 0, 0, 0, 0, 0, 0, O_RE);
    add("st_cmp",    0, 0, 0, 8'h09, 0, 1, 0, 1, 1, 0, 0, 0, O_WE0 | O_TCH | O_DC | O_DSET | O_DN);
    add("st_back",   0, 0, 0, 8'h09, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    // double hit selects way0
    add("dh_idle",   0, 1, 0, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0, O_RE);
    add("dh_cmp",    0, 0, 0, 8'h03, 0, 1, 1, 1, 1, 0, 0, 0, O_DN);
    // load miss, clean victim way0, ack on 3rd ALLOCATE cycle; req_valid ignored
    add("lm_idle",   0, 1, 0, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0, O_RE);
    add("lm_cmp",    0, 0, 0, 8'h20, 0, 0, 0, 1, 1, 0, 0, 0, O_MS);
    add("lm_al1",    0, 1, 0, 8'h20, 0, 0, 0, 1, 1, 0, 0, 0, O_L2R | O_MS);
    add("lm_al2",    0, 1, 0, 8'h20, 0, 0, 0, 1, 1, 0, 0, 0, O_L2R | O_MS);
    add("lm_al3",    0, 0, 0, 8'h20, 0, 0, 0, 1, 1, 0, 0, 1, O_L2R | O_MS | O_WE0 | O_L2EN | O_TWE);
    add("lm_rf",     0, 1, 0, 8'h20, 0, 0, 0, 1, 1, 0, 0, 1, O_RE | O_MS);
    add("lm_cmp2",   0, 0, 0, 8'h20, 0, 1, 0, 1, 1, 0, 0, 0, O_DN);
    add("lm_back",   0, 0, 0, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    // store miss, dirty victim way0: writeback then fill with merge
    add("rst_f",     1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    add("sm_idle",   0, 1, 1, 8'h40, 1, 0, 0, 0, 0, 0, 0, 0, O_RE);
    add("sm_cmp",    0, 0, 0, 8'h40, 0, 0, 0, 1, 1, 1, 1, 0, O_MS);
    add("sm_wb1",    0, 0, 0, 8'h40, 0, 0, 0, 1, 1, 1, 1, 0, O_L2R | O_RW | O_MS);
    add("sm_wb2",    0, 0, 0, 8'h40, 0, 0, 0, 1, 1, 1, 1, 1, O_L2R | O_RW | O_MS | O_DCLR);
    add("sm_al1",    0, 0, 0, 8'h40, 0, 0, 0, 1, 1, 0, 1, 0, O_L2R | O_MS);
    add("sm_al2",    0, 0, 0, 8'h40, 0, 0, 0, 1, 1, 0, 1, 1,
        O_L2R | O_MS | O_WE0 | O_L2EN | O_TWE | O_DC | O_DSET);
    add("sm_rf",     0, 0, 0, 8'h40, 0, 0, 0, 1, 1, 1, 1, 0, O_RE | O_MS);
    add("sm_cmp2",   0, 0, 0, 8'h40, 0, 1, 0, 1, 1, 1, 1, 0, O_DN);
    add("sm_back",   0, 0, 0, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    // invalid way1 preferred, then reset in the 2nd ALLOCATE wait cycle
    add("rm_idle",   0, 1, 0, 8'h50, 0, 0, 0, 0, 0, 0, 0, 0, O_RE);
    add("rm_cmp",    0, 0, 0, 8'h50, 0, 0, 0, 1, 0, 0, 0, 0, O_MS | O_VIC);
    add("rm_al1",    0, 0, 0, 8'h50, 0, 0, 0, 1, 0, 0, 0, 0, O_L2R | O_MS | O_VIC);
    add("rm_al2",    1, 0, 0, 8'h50, 0, 0, 0, 1, 0, 0, 0, 0, O_L2R | O_MS | O_VIC);
    add("rm_after",  0, 0, 0, 8'h50, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    add("rm_ackidl", 0, 0, 0, 8'h50, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0);
    // hit way0 at index 7, then miss at 7 with both ways valid
    add("lr_idle",   0, 1, 0, 8'h07, 0, 0, 0, 0, 0, 0, 0, 0, O_RE);
    add("lr_cmp",    0, 0, 0, 8'h07, 0, 1, 0, 1, 1, 0, 0, 0, O_DN);
    add("lr_idle2",  0, 1, 0, 8'h07, 0, 0, 0, 0, 0, 0, 0, 0, O_RE);
    add("lr_cmp2",   0, 0, 0, 8'h07, 0, 0, 0, 1, 1, 0, 0, 0, O_MS | LRU_VIC);
    add("rst_end",   1, 0, 0, 8'h07, 0, 0, 0, 1, 1, 0, 0, 0, O_L2R | O_MS | LRU_VIC);
    add("end",       0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);

    rst = 1'b1; req_valid = 0; req_we = 0; index = 0; offset = 0;
    hit0 = 0; hit1 = 0; valid0 = 0; valid1 = 0; dirty0 = 0; dirty1 = 0; l2_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    foreach (tv[i]) begin
      rst = tv[i].r; req_valid = tv[i].rv; req_we = tv[i].we; index = tv[i].idx;
      offset = tv[i].off; hit0 = tv[i].h0; hit1 = tv[i].h1; valid0 = tv[i].v0;
      valid1 = tv[i].v1; dirty0 = tv[i].d0; dirty1 = tv[i].d1; l2_ack = tv[i].ack;
      #1;
      check(tv[i].nm, {16'h0, outs()}, {16'h0, tv[i].exp});
      @(posedge clk);
      #1;
    end

    // Load miss into invalid way1 with a variable L2 wait.
    for (int n = 1; n <= 4; n += 3) begin
      int areq, ms, we1, vic1, rfseen, dn;
      areq = 0; ms = 0; we1 = 0; vic1 = 0; rfseen = 0; dn = 0;
      rst = 0; req_valid = 1; req_we = 0; index = 8'h11; offset = 0;
      hit0 = 0; hit1 = 0; valid0 = 1; valid1 = 0; dirty0 = 0; dirty1 = 0; l2_ack = 0;
      @(posedge clk);
      #1;
      req_valid = 0;
      for (int c = 0; c < 30 && dn == 0; c++) begin
        l2_ack = 0;
        hit1 = (rfseen != 0);
        #1;
        if (l2_req) begin
          areq++;
          if (areq == n) l2_ack = 1;
        end
        #1;
        if (miss_stall) ms++;
        if (block1_we) we1++;
        if (c == 0 && victim_way) vic1 = 1;
        if (block1_re && miss_stall) rfseen = 1;
        if (req_done) dn = 1;
        @(posedge clk);
        #1;
      end
      l2_ack = 0; hit1 = 0;
      check("seq_done",  dn,   1);
      check("seq_stall", ms,   n + 2);
      check("seq_l2req", areq, n);
      check("seq_we1",   we1,  1);
      check("seq_vic1",  vic1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
